// File: rtl/sd_cmd_seq.sv
// SD-card SPI command sequencer: drops CS, sends a 6-byte command frame, polls for R1,
// then optionally raises CS and clocks trailing 0xFF bytes through the byte-level SPI controller.
module sd_cmd_seq #(
  parameter int unsigned RESP_TIMEOUT = 8,
  parameter int unsigned TRAIL_BYTES  = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [5:0]  cmd_idx_i,
  input  logic [31:0] arg_i,
  input  logic [6:0]  crc_i,
  input  logic        hold_cs_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  resp_o,
  output logic        timeout_o,
  output logic        spi_ce_o,
  output logic        spi_we_o,
  output logic        spi_func_o,
  output logic [7:0]  spi_data_o,
  input  logic [7:0]  spi_data_i,
  input  logic        spi_val_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_CS_LO, S_CS_LO_W, S_FRAME, S_FRAME_W, S_POLL_WR, S_POLL_WR_W,
    S_POLL_RD, S_POLL_RD_W, S_CS_HI, S_CS_HI_W, S_TRAIL, S_TRAIL_W, S_DONE
  } state_e;

  state_e      state_q, state_d, end_state;
  logic [5:0]  cmd_idx_q, cmd_idx_d;
  logic [31:0] arg_q, arg_d;
  logic [6:0]  crc_q, crc_d;
  logic        hold_q, hold_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic [3:0]  trail_cnt_q, trail_cnt_d;
  logic [7:0]  resp_q, resp_d;
  logic        timeout_q, timeout_d;

  // Where a finished poll goes: straight to DONE when CS must stay low for a data phase.
  assign end_state = hold_q ? S_DONE : S_CS_HI;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cmd_idx_q   <= '0;
      arg_q       <= '0;
      crc_q       <= '0;
      hold_q      <= 1'b0;
      byte_cnt_q  <= '0;
      poll_cnt_q  <= '0;
      trail_cnt_q <= '0;
      resp_q      <= 8'hFF;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_idx_q   <= cmd_idx_d;
      arg_q       <= arg_d;
      crc_q       <= crc_d;
      hold_q      <= hold_d;
      byte_cnt_q  <= byte_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      trail_cnt_q <= trail_cnt_d;
      resp_q      <= resp_d;
      timeout_q   <= timeout_d;
    end
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    cmd_idx_d   = cmd_idx_q;
    arg_d       = arg_q;
    crc_d       = crc_q;
    hold_d      = hold_q;
    byte_cnt_d  = byte_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    trail_cnt_d = trail_cnt_q;
    resp_d      = resp_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        cmd_idx_d   = cmd_idx_i;
        arg_d       = arg_i;
        crc_d       = crc_i;
        hold_d      = hold_cs_i;
        byte_cnt_d  = '0;
        poll_cnt_d  = '0;
        trail_cnt_d = '0;
        timeout_d   = 1'b0;
        state_d     = S_CS_LO;
      end
      S_CS_LO:   state_d = S_CS_LO_W;
      S_CS_LO_W: if (spi_val_i) state_d = S_FRAME;
      S_FRAME:   state_d = S_FRAME_W;
      S_FRAME_W: if (spi_val_i) begin
        if (byte_cnt_q == 3'd5) begin
          state_d = S_POLL_WR;
        end else begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          state_d    = S_FRAME;
        end
      end
      S_POLL_WR:   state_d = S_POLL_WR_W;
      S_POLL_WR_W: if (spi_val_i) state_d = S_POLL_RD;
      S_POLL_RD:   state_d = S_POLL_RD_W;
      // The response check is folded into the read completion so done follows the read val directly.
      S_POLL_RD_W: if (spi_val_i) begin
        if (!spi_data_i[7]) begin
          resp_d  = spi_data_i;
          state_d = end_state;
        end else begin
          poll_cnt_d = poll_cnt_q + 8'd1;
          if (poll_cnt_d == 8'(RESP_TIMEOUT)) begin
            timeout_d = 1'b1;
            resp_d    = 8'hFF;
            state_d   = end_state;
          end else begin
            state_d = S_POLL_WR;
          end
        end
      end
      S_CS_HI:   state_d = S_CS_HI_W;
      S_CS_HI_W: if (spi_val_i) state_d = (TRAIL_BYTES == 0) ? S_DONE : S_TRAIL;
      S_TRAIL:   state_d = S_TRAIL_W;
      S_TRAIL_W: if (spi_val_i) begin
        if (trail_cnt_q == 4'(TRAIL_BYTES - 1)) begin
          state_d = S_DONE;
        end else begin
          trail_cnt_d = trail_cnt_q + 4'd1;
          state_d     = S_TRAIL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    spi_ce_o   = 1'b0;
    spi_we_o   = 1'b0;
    spi_func_o = 1'b0;
    spi_data_o = 8'h00;
    unique case (state_q)
      S_CS_LO: begin
        spi_ce_o   = 1'b1;
        spi_we_o   = 1'b1;
        spi_func_o = 1'b1;
      end
      S_FRAME: begin
        spi_ce_o = 1'b1;
        spi_we_o = 1'b1;
        unique case (byte_cnt_q)
          3'd0:    spi_data_o = {2'b01, cmd_idx_q};
          3'd1:    spi_data_o = arg_q[31:24];
          3'd2:    spi_data_o = arg_q[23:16];
          3'd3:    spi_data_o = arg_q[15:8];
          3'd4:    spi_data_o = arg_q[7:0];
          default: spi_data_o = {crc_q, 1'b1};
        endcase
      end
      S_POLL_WR, S_TRAIL: begin
        spi_ce_o   = 1'b1;
        spi_we_o   = 1'b1;
        spi_data_o = 8'hFF;
      end
      S_POLL_RD: spi_ce_o = 1'b1;
      S_CS_HI: begin
        spi_ce_o   = 1'b1;
        spi_we_o   = 1'b1;
        spi_func_o = 1'b1;
        spi_data_o = 8'h01;
      end
      default: ;
    endcase
  end

  assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o    = (state_q == S_DONE);
  assign resp_o    = resp_q;
  assign timeout_o = timeout_q;

endmodule
